// File: rtl/binary_to_gray_block_pkg.sv
`default_nettype none
// ============================================================================
// Module   : binary_to_gray_block_pkg
// Purpose  : Shared constants and reference conversion functions for the
//            binary/Gray converter block.
// Revision : 1.0 - initial release
// ============================================================================
package binary_to_gray_block_pkg;

    localparam int c_DEFAULT_WIDTH = 3;
    localparam int c_MAX_WIDTH     = 32;

    localparam logic DIR_ENC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

    // Operands are zero-extended to the maximum width; zero upper bits do
    // not disturb either conversion, so one function serves every WIDTH.
    function automatic logic [c_MAX_WIDTH-1:0] bin2gray(input logic [c_MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [c_MAX_WIDTH-1:0] gray2bin(input logic [c_MAX_WIDTH-1:0] g);
        logic [c_MAX_WIDTH-1:0] r;
        r[c_MAX_WIDTH-1] = g[c_MAX_WIDTH-1];
        for (int i = c_MAX_WIDTH - 2; i >= 0; i--) begin
            r[i] = r[i+1] ^ g[i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/binary_to_gray_block_gray_xor_core.sv
`default_nettype none
// ============================================================================
// Module   : gray_xor_core
// Purpose  : Combinational binary-to-Gray encode / Gray-to-binary decode.
// Revision : 1.0 - initial release
// ============================================================================
module gray_xor_core
    import binary_to_gray_block_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             dir,
    input  logic [WIDTH-1:0] word_in,
    output logic [WIDTH-1:0] word_out
);

    logic [WIDTH-1:0] w_enc;
    logic [WIDTH-1:0] w_dec;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            if (i == WIDTH - 1) begin : g_msb
                assign w_enc[i] = word_in[i];
            end else begin : g_lsb
                assign w_enc[i] = word_in[i] ^ word_in[i+1];
            end
            // Each decoded bit is the XOR of all Gray bits at or above it,
            // written as a reduction to keep the logic free of a bit chain.
            assign w_dec[i] = ^word_in[WIDTH-1:i];
        end
    endgenerate

    always_comb begin
        word_out = w_enc;
        if (dir == DIR_DEC) begin
            word_out = w_dec;
        end
    end

endmodule
`default_nettype wire

// File: rtl/binary_to_gray_block.sv
`default_nettype none
// ============================================================================
// Module   : binary_to_gray_block
// Purpose  : Registered, one-cycle-latency binary/Gray converter.
// Revision : 1.0 - initial release
// ============================================================================
module binary_to_gray_block
    import binary_to_gray_block_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             dir,
    input  logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] gray,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_conv;
    logic [WIDTH-1:0] r_gray;
    logic             r_out_valid;

    gray_xor_core #(
        .WIDTH    (WIDTH)
    ) u_core (
        .dir      (dir),
        .word_in  (binary),
        .word_out (w_conv)
    );

    // Result register holds its value when no input is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gray      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_gray <= w_conv;
            end
        end
    end

    assign gray      = r_gray;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_binary_to_gray_block.sv
`default_nettype none
// ============================================================================
// Module   : tb_binary_to_gray_block
// Purpose  : Directed self-checking bench for binary_to_gray_block.
// Revision : 1.0 - initial release
// ============================================================================
module tb_binary_to_gray_block;

    logic       clk;
    logic       rst;

    logic       in_valid3;
    logic       dir3;
    logic [2:0] bin3;
    logic [2:0] gray3;
    logic       ov3;

    logic       in_valid8;
    logic       dir8;
    logic [7:0] bin8;
    logic [7:0] gray8;
    logic       ov8;

    int n_pass;
    int n_total;

    binary_to_gray_block #(.WIDTH(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid3),
        .dir       (dir3),
        .binary    (bin3),
        .gray      (gray3),
        .out_valid (ov3)
    );

    binary_to_gray_block #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .dir       (dir8),
        .binary    (bin8),
        .gray      (gray8),
        .out_valid (ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge: drive, then wait to the next negedge where the
    // registered result is visible.
    task automatic apply3(input logic v, input logic d, input logic [2:0] b);
        in_valid3 = v;
        dir3      = d;
        bin3      = b;
        @(negedge clk);
    endtask

    task automatic apply8(input logic v, input logic d, input logic [7:0] b);
        in_valid8 = v;
        dir8      = d;
        bin8      = b;
        @(negedge clk);
    endtask

    logic [2:0] gtab  [8];
    logic [7:0] rt_b  [5];
    logic [7:0] rt_g  [5];
    logic [2:0] alt_b [6];
    logic [2:0] alt_r [6];
    logic [7:0] rw;
    logic [7:0] rg;
    logic [7:0] enc_out;

    initial begin
        n_pass  = 0;
        n_total = 0;
        gtab  = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        rt_b  = '{8'hA5, 8'h3C, 8'hFF, 8'h01, 8'h80};
        rt_g  = '{8'hF7, 8'h22, 8'h80, 8'h01, 8'hC0};
        alt_b = '{3'd5, 3'd7, 3'd2, 3'd4, 3'd6, 3'd3};
        alt_r = '{3'd7, 3'd5, 3'd3, 3'd7, 3'd5, 3'd2};

        rst       = 1'b1;
        in_valid3 = 1'b0; dir3 = 1'b0; bin3 = '0;
        in_valid8 = 1'b0; dir8 = 1'b0; bin8 = '0;
        #1;
        chk("reset_gray3", {29'd0, gray3}, 32'd0);
        chk("reset_ov3",   {31'd0, ov3},   32'd0);
        chk("reset_gray8", {24'd0, gray8}, 32'd0);
        chk("reset_ov8",   {31'd0, ov8},   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Exhaustive encode, back to back
        for (int i = 0; i < 8; i++) begin
            apply3(1'b1, 1'b0, 3'(i));
            chk($sformatf("enc_%0d", i), {29'd0, gray3}, {29'd0, gtab[i]});
            chk($sformatf("enc_ov_%0d", i), {31'd0, ov3}, 32'd1);
        end

        // Exhaustive decode, back to back
        for (int i = 0; i < 8; i++) begin
            apply3(1'b1, 1'b1, gtab[i]);
            chk($sformatf("dec_%0d", i), {29'd0, gray3}, i);
            chk($sformatf("dec_ov_%0d", i), {31'd0, ov3}, 32'd1);
        end

        // Hold behaviour
        apply3(1'b1, 1'b0, 3'b101);
        chk("hold_first", {29'd0, gray3}, 32'b111);
        chk("hold_first_ov", {31'd0, ov3}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            apply3(1'b0, 1'b1, 3'b010);
            chk($sformatf("hold_%0d", i), {29'd0, gray3}, 32'b111);
            chk($sformatf("hold_ov_%0d", i), {31'd0, ov3}, 32'd0);
        end

        // Asynchronous reset between edges, with a valid input discarded
        apply3(1'b1, 1'b0, 3'b111);
        chk("pre_rst", {29'd0, gray3}, 32'b100);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_gray", {29'd0, gray3}, 32'd0);
        chk("async_rst_ov",   {31'd0, ov3},   32'd0);
        @(negedge clk);
        chk("rst_discard_gray", {29'd0, gray3}, 32'd0);
        chk("rst_discard_ov",   {31'd0, ov3},   32'd0);
        rst = 1'b0;
        apply3(1'b0, 1'b0, 3'b000);
        chk("post_rst_idle_ov", {31'd0, ov3}, 32'd0);
        apply3(1'b1, 1'b0, 3'b011);
        chk("post_rst_first", {29'd0, gray3}, 32'b010);
        chk("post_rst_first_ov", {31'd0, ov3}, 32'd1);

        // Back-to-back with alternating direction
        for (int i = 0; i < 6; i++) begin
            apply3(1'b1, 1'(i % 2), alt_b[i]);
            chk($sformatf("alt_%0d", i), {29'd0, gray3}, {29'd0, alt_r[i]});
            chk($sformatf("alt_ov_%0d", i), {31'd0, ov3}, 32'd1);
        end
        apply3(1'b0, 1'b0, 3'b000);
        chk("alt_end_ov", {31'd0, ov3}, 32'd0);

        // WIDTH=8 round trip, hand-computed vectors
        for (int i = 0; i < 5; i++) begin
            apply8(1'b1, 1'b0, rt_b[i]);
            chk($sformatf("rt_enc_%0h", rt_b[i]), {24'd0, gray8}, {24'd0, rt_g[i]});
            enc_out = gray8;
            apply8(1'b1, 1'b1, enc_out);
            chk($sformatf("rt_dec_%0h", rt_b[i]), {24'd0, gray8}, {24'd0, rt_b[i]});
        end

        // WIDTH=8 round trip, random words
        for (int i = 0; i < 6; i++) begin
            rw = 8'($urandom_range(0, 255));
            rg = rw ^ (rw >> 1);
            apply8(1'b1, 1'b0, rw);
            chk($sformatf("rnd_enc_%0h", rw), {24'd0, gray8}, {24'd0, rg});
            enc_out = gray8;
            apply8(1'b1, 1'b1, enc_out);
            chk($sformatf("rnd_dec_%0h", rw), {24'd0, gray8}, {24'd0, rw});
            chk($sformatf("rnd_ov_%0h", rw), {31'd0, ov8}, 32'd1);
        end
        apply8(1'b0, 1'b0, 8'h00);
        chk("rt_idle_ov", {31'd0, ov8}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/binary_to_gray_block.md
BINARY_TO_GRAY_BLOCK -- requirements
Module: binary_to_gray

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: WIDTH, default 3, code word width in bits; legal range 1..32.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: in_valid  input  1  qualifies binary and dir this cycle.
REQ-006 Port: dir  input  1  0 = binary-to-Gray encode, 1 = Gray-to-binary decode.
REQ-007 Port: binary  input  WIDTH  operand word, binary for encode, Gray for decode.
REQ-008 Port: gray  output  WIDTH  registered conversion result.
REQ-009 Port: out_valid  output  1  high for exactly one cycle per accepted input.

Function
REQ-010 Encode (dir=0) SHALL compute gray[i] = binary[i] XOR binary[i+1] for i < WIDTH-1, with gray[WIDTH-1] = binary[WIDTH-1].
REQ-011 Decode (dir=1) SHALL compute result[WIDTH-1] = binary[WIDTH-1] and result[i] = result[i+1] XOR binary[i] (prefix XOR from MSB downward).
REQ-012 Latency SHALL be exactly 1 clock: an input sampled with in_valid=1 on edge N appears on gray with out_valid=1 after edge N.
REQ-013 The block SHALL accept one input per cycle with no backpressure; back-to-back in_valid gives back-to-back out_valid.
REQ-014 When in_valid=0, gray SHALL hold its last value and out_valid SHALL be 0 on the next cycle.
REQ-015 The result SHALL be purely bitwise (no carries); all WIDTH bits are significant, and there is no overflow case.
REQ-016 WIDTH=1 SHALL degenerate to gray = binary in both directions.
REQ-017 Encode followed by decode of the same word SHALL return the original word for every value.

Reset
REQ-018 When rst is asserted, gray SHALL be forced to all zeros and out_valid to 0 immediately, independent of clk.
REQ-019 An input presented in the same cycle that rst is asserted SHALL be discarded.
REQ-020 After rst deasserts, the first in_valid sampled on a rising edge SHALL be processed normally.
REQ-021 Reset mid-stream SHALL drop any in-flight result; out_valid SHALL not pulse for it.

Structure
REQ-022 A shared package SHALL hold the WIDTH default constant, the dir encoding constants (DIR_ENC=0, DIR_DEC=1) and pure conversion functions bin2gray and gray2bin.
REQ-023 One combinational sub-module, gray_xor_core (WIDTH parameter, dir, word in, word out), SHALL implement REQ-010/011.
REQ-024 The top SHALL contain only the input qualification, the output register and the valid register.

Verification
REQ-025 Exhaustive encode for WIDTH=3: drive binary 0..7 with dir=0, one per cycle. The required gray outputs one cycle later are 000, 001, 011, 010, 110, 111, 101, 100.
REQ-026 Exhaustive decode for WIDTH=3: drive Gray codes 000, 001, 011, 010, 110, 111, 101, 100 with dir=1. The required outputs are 0..7 in order.
REQ-027 Hold: drive 3'b101 with dir=0 and in_valid=1, then set in_valid=0 for 3 cycles. gray SHALL stay 3'b111, and out_valid SHALL be high only in the first cycle.
REQ-028 Async reset: after gray=3'b100, assert rst between clock edges. gray SHALL become 000 and out_valid 0 without waiting for a clk edge.
REQ-029 Round trip for WIDTH=8: encode random words, feed each result back with dir=1. Every output SHALL equal the original word (e.g. 8'hA5 -> 8'hF7 -> 8'hA5).
REQ-030 Back-to-back operation: alternate dir every cycle with in_valid held high. out_valid SHALL stay continuously 1 and each result SHALL match the package function for its input.
